// File: rtl/apb_mem_slave_if.sv
// APB3 bus bundle between one master and one memory completer.
interface apb_mem_slave_if #(
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB3 completer backing a DEPTH-word register memory with alignment/range error reporting.
// Optional wait states are enabled by defining APB_SLV_WAIT_EN.
module apb_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input logic             PCLK,
    input logic             PRESETn,
    apb_mem_slave_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx_q;
    logic              wr_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [3:0]        cnt;

    logic              setup;
    logic              setup_err;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    assign setup     = (state == IDLE) & bus.PSEL & ~bus.PENABLE;
    assign setup_err = (bus.PADDR[1:0] != 2'b00) | (bus.PADDR[30:2] >= 29'(DEPTH));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        case (state)
            IDLE: begin
                if (bus.PSEL) begin
                    // Access phase with no preceding setup: flag it without touching memory
                    if (bus.PENABLE) begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0 && bus.PENABLE) begin
                    pready    = 1'b1;
                    pslverr   = err_q;
                    state_nxt = IDLE;
                    if (!wr_q && !err_q) prdata = mem[idx_q];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced to their reset values while PRESETn is held low
    assign bus.PREADY  = pready & PRESETn;
    assign bus.PSLVERR = pslverr & PRESETn;
    assign bus.PRDATA  = PRESETn ? prdata : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else if (setup) begin
            idx_q   <= bus.PADDR[AW+1:2];
            wr_q    <= bus.PWRITE;
            err_q   <= setup_err;
            wdata_q <= bus.PWDATA;
        end
    end

`ifdef APB_SLV_WAIT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                          cnt <= 4'd0;
        else if (setup)                        cnt <= 4'(WAIT_CYCLES);
        else if (state == ACCESS && cnt != 0)  cnt <= cnt - 4'd1;
    end
`else
    assign cnt = 4'd0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == ACCESS && pready && wr_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // PADDR[31] is the upstream slave-select bit
    logic unused_ok;
    assign unused_ok = ^{bus.PADDR[31], 4'(WAIT_CYCLES)};
endmodule
